instr_ram_ctrl: RTL and testbench

Parametrised instruction memory controller between the UART byte receiver and the CPU fetch path. It assembles delimited UART byte streams into DATA_W-bit words and writes them to a DEPTH-entry RAM. The stored program is available three ways: a valid/ready replay stream, single-step debug readout, and random-access CPU fetch. A fill count replaces the zero-word end-of-program convention, so zero-valued instructions are legal.

---
 rtl/instr_ram_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_instr_ram_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_ram_ctrl.sv
// -----------------------------------------------------------------------------
// instr_ram_ctrl
//
// Instruction memory controller sitting between the UART byte receiver and the
// CPU fetch path. Delimited UART byte streams are packed LSB-first into DATA_W
// words and written into a DEPTH-entry RAM. The stored program can be read back
// as a valid/ready replay stream, stepped through one word at a time from a
// debug button, or fetched at random by the CPU. Program length is tracked by a
// fill count, so an all-zero instruction word is a legal program word.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   mode[1:0]    0 STREAM, 1 LOAD, 2 DEBUG, 3 FETCH
//   wr_byte      UART byte (LOAD)
//   wr_valid     wr_byte valid this cycle
//   rd_ready     stream consumer ready (STREAM)
//   rd_data      stream or debug word
//   rd_valid     rd_data valid
//   dbg_step     asynchronous step button, active-high (DEBUG)
//   fetch_en     fetch request (FETCH)
//   fetch_addr   fetch address
//   fetch_data   fetched word, 0 for addresses beyond the program
//   fetch_valid  one-cycle pulse qualifying fetch_data
//   count        number of committed words
//   full         count == DEPTH
//   overflow     sticky: a word was committed while full and was dropped
// -----------------------------------------------------------------------------
module instr_ram_ctrl #(
    parameter int         DATA_W = 8,
    parameter int         DEPTH  = 256,
    parameter int         ADDR_W = $clog2(DEPTH),
    parameter logic [7:0] DELIM  = 8'h24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [7:0]        wr_byte,
    input  logic              wr_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              dbg_step,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BCNT_W = $clog2(BYTES + 1);

    localparam logic [1:0] M_STREAM = 2'd0;
    localparam logic [1:0] M_LOAD   = 2'd1;
    localparam logic [1:0] M_DEBUG  = 2'd2;
    localparam logic [1:0] M_FETCH  = 2'd3;

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [BCNT_W-1:0] BCNT_MAX = BYTES[BCNT_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_VALID = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Mode tracking
    // ------------------------------------------------------------------
    logic [1:0] r_mode_prev;
    logic       w_mode_chg;
    logic       w_enter_load;
    logic       w_enter_stream;
    logic       w_enter_dbg;

    assign w_mode_chg     = (mode != r_mode_prev);
    assign w_enter_load   = w_mode_chg && (mode == M_LOAD);
    assign w_enter_stream = w_mode_chg && (mode == M_STREAM);
    assign w_enter_dbg    = w_mode_chg && (mode == M_DEBUG);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_prev <= M_STREAM;
        end else begin
            r_mode_prev <= mode;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_ram [DEPTH];
    logic [DATA_W-1:0] r_ram_q;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;

    // ------------------------------------------------------------------
    // LOAD: byte assembly and commit
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_acc_shift;
    logic [BCNT_W-1:0] r_byte_cnt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              w_full;
    logic              w_load_act;
    logic              w_is_delim;
    logic              w_commit;

    // Newest byte enters the top lane and every other lane moves down one,
    // so after DATA_W/8 bytes the first byte received sits in the LSB lane.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            if (gi == BYTES - 1) begin : g_top
                assign w_acc_shift[8*gi +: 8] = wr_byte;
            end else begin : g_mid
                assign w_acc_shift[8*gi +: 8] = r_acc[8*(gi+1) +: 8];
            end
        end
    endgenerate

    assign w_full     = (r_count == CNT_FULL);
    // The cycle that enters LOAD is spent clearing state; a byte arriving
    // in that same cycle is not taken.
    assign w_load_act = !rst && (mode == M_LOAD) && !w_enter_load && wr_valid;
    assign w_is_delim = (wr_byte == DELIM);
    assign w_commit   = w_load_act && w_is_delim && (r_byte_cnt != '0) && !w_full;

    always_ff @(posedge clk) begin
        if (rst || w_enter_load) begin
            r_acc      <= '0;
            r_byte_cnt <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_load_act) begin
            if (!w_is_delim) begin
                r_acc <= w_acc_shift;
                if (r_byte_cnt != BCNT_MAX) begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                end
            end else if (r_byte_cnt != '0) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                    r_count  <= r_count + CNT_ONE;
                end
                r_acc      <= '0;
                r_byte_cnt <= '0;
            end
        end
    end

    // RAM array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_ram[r_wr_ptr] <= r_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_en) begin
            r_ram_q <= r_ram[w_rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // STREAM: replay FSM
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_eff;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   w_rd_ptr_p1;
    logic              w_rd_ptr_adv;
    logic              w_stream_valid;

    assign w_rd_ptr_p1 = {1'b0, r_rd_ptr} + CNT_ONE;

    always_comb begin
        // On the entry cycle the FSM behaves as if already idle, which puts
        // the first read one cycle later and the first valid two cycles in.
        w_state_eff    = w_enter_stream ? S_IDLE : r_state;
        w_state_next   = w_state_eff;
        w_rd_ptr_adv   = 1'b0;
        w_stream_valid = 1'b0;
        case (w_state_eff)
            S_IDLE: begin
                w_state_next = (r_count != '0) ? S_RD : S_DONE;
            end
            S_RD: begin
                w_state_next = S_VALID;
            end
            S_VALID: begin
                w_stream_valid = 1'b1;
                if (rd_ready) begin
                    w_rd_ptr_adv = 1'b1;
                    w_state_next = (w_rd_ptr_p1 < r_count) ? S_RD : S_DONE;
                end
            end
            default: begin
                w_state_next = S_DONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (mode == M_STREAM) begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_enter_stream) begin
            r_rd_ptr <= '0;
        end else if ((mode == M_STREAM) && w_rd_ptr_adv) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // DEBUG: step synchroniser and pointer
    // ------------------------------------------------------------------
    logic              r_sync1;
    logic              r_sync2;
    logic              r_step_prev;
    logic              w_step_rise;
    logic [ADDR_W-1:0] r_dbg_ptr;
    logic [ADDR_W:0]   w_dbg_ptr_p1;

    // The synchroniser runs in every mode so a button held across a mode
    // change never produces a spurious edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_sync1     <= dbg_step;
            r_sync2     <= r_sync1;
            r_step_prev <= r_sync2;
        end
    end

    assign w_step_rise  = r_sync2 && !r_step_prev;
    assign w_dbg_ptr_p1 = {1'b0, r_dbg_ptr} + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst || w_enter_dbg) begin
            r_dbg_ptr <= '0;
        end else if ((mode == M_DEBUG) && w_step_rise && (w_dbg_ptr_p1 < r_count)) begin
            r_dbg_ptr <= r_dbg_ptr + PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // FETCH
    // ------------------------------------------------------------------
    logic r_fetch_valid;
    logic r_fetch_hit;
    logic w_fetch_req;

    assign w_fetch_req = (mode == M_FETCH) && fetch_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_valid <= 1'b0;
            r_fetch_hit   <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_req;
            r_fetch_hit   <= w_fetch_req && ({1'b0, fetch_addr} < r_count);
        end
    end

    // ------------------------------------------------------------------
    // Shared read port: only one mode reads at a time.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = r_rd_ptr;
        case (mode)
            M_STREAM: begin
                // Only reload in S_RD so the word holds through a stall.
                w_rd_en   = (w_state_eff == S_RD);
                w_rd_addr = r_rd_ptr;
            end
            M_DEBUG: begin
                w_rd_en   = 1'b1;
                w_rd_addr = w_enter_dbg ? '0 : r_dbg_ptr;
            end
            M_FETCH: begin
                w_rd_en   = fetch_en;
                w_rd_addr = fetch_addr;
            end
            default: begin
                w_rd_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        rd_valid = 1'b0;
        if (!w_mode_chg) begin
            if (mode == M_STREAM) begin
                rd_valid = w_stream_valid;
            end else if (mode == M_DEBUG) begin
                rd_valid = (r_count != '0);
            end
        end
    end

    assign rd_data     = rd_valid ? r_ram_q : '0;
    assign fetch_valid = r_fetch_valid && !w_mode_chg;
    // Out-of-range addresses return zero without trusting stale RAM output.
    assign fetch_data  = (fetch_valid && r_fetch_hit) ? r_ram_q : '0;
    assign count       = r_count;
    assign full        = w_full;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_instr_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_ram_ctrl
//
// Directed bench for instr_ram_ctrl. Two instances share stimulus:
//   u_dut_a : DATA_W=8,  DEPTH=8  (load/stream/stall/debug/fetch/reset)
//   u_dut_b : DATA_W=16, DEPTH=4  (multi-byte assembly, full/overflow)
// Expected values are written out by hand next to each check.
// -----------------------------------------------------------------------------
module tb_instr_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [7:0]  wr_byte;
    logic        wr_valid;
    logic        rd_ready;
    logic        dbg_step;
    logic        fetch_en;
    logic [2:0]  fetch_addr_a;
    logic [1:0]  fetch_addr_b;

    logic [7:0]  rd_data_a;
    logic        rd_valid_a;
    logic [7:0]  fetch_data_a;
    logic        fetch_valid_a;
    logic [3:0]  count_a;
    logic        full_a;
    logic        overflow_a;

    logic [15:0] rd_data_b;
    logic        rd_valid_b;
    logic [15:0] fetch_data_b;
    logic        fetch_valid_b;
    logic [2:0]  count_b;
    logic        full_b;
    logic        overflow_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    instr_ram_ctrl #(.DATA_W(8), .DEPTH(8)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .wr_byte     (wr_byte),
        .wr_valid    (wr_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data_a),
        .rd_valid    (rd_valid_a),
        .dbg_step    (dbg_step),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr_a),
        .fetch_data  (fetch_data_a),
        .fetch_valid (fetch_valid_a),
        .count       (count_a),
        .full        (full_a),
        .overflow    (overflow_a)
    );

    instr_ram_ctrl #(.DATA_W(16), .DEPTH(4)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .wr_byte     (wr_byte),
        .wr_valid    (wr_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data_b),
        .rd_valid    (rd_valid_b),
        .dbg_step    (dbg_step),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr_b),
        .fetch_data  (fetch_data_b),
        .fetch_valid (fetch_valid_b),
        .count       (count_b),
        .full        (full_b),
        .overflow    (overflow_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("[%0t] %-16s got=0x%0h exp=0x%0h ok", $time, tag, got, exp);
        end else begin
            $display("[%0t] FAIL %-16s got=0x%0h exp=0x%0h", $time, tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        wr_byte  = b;
        wr_valid = 1'b1;
        step(1);
        wr_valid = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        step(1);
    endtask

    logic [7:0] dbg_exp [5];

    initial begin
        rst = 1'b1; mode = 2'd0; wr_byte = 8'h00; wr_valid = 1'b0;
        rd_ready = 1'b0; dbg_step = 1'b0; fetch_en = 1'b0;
        fetch_addr_a = 3'd0; fetch_addr_b = 2'd0;
        dbg_exp[0] = 8'h00; dbg_exp[1] = 8'h42; dbg_exp[2] = 8'h42;
        dbg_exp[3] = 8'h42; dbg_exp[4] = 8'h42;
        step(3);
        rst = 1'b0;

        // Reset state
        check_eq("rst_count",    32'(count_a), 32'd0);
        check_eq("rst_full",     32'(full_a), 32'd0);
        check_eq("rst_ovf",      32'(overflow_a), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid_a), 32'd0);
        check_eq("rst_fvalid",   32'(fetch_valid_a), 32'd0);

        // 1: load 0x41,$,0x00,$,0x42,$ then stream it back
        set_mode(2'd1);
        send_byte(8'h41); send_byte(8'h24);
        send_byte(8'h00); send_byte(8'h24);
        send_byte(8'h42); send_byte(8'h24);
        check_eq("t1_count_a", 32'(count_a), 32'd3);
        check_eq("t1_count_b", 32'(count_b), 32'd3);

        rd_ready = 1'b1;
        mode = 2'd0;
        step(1);
        check_eq("t1_lat_valid", 32'(rd_valid_a), 32'd0);
        step(1);
        check_eq("t1_w0_valid", 32'(rd_valid_a), 32'd1);
        check_eq("t1_w0_data",  32'(rd_data_a), 32'h41);
        check_eq("t1_w0_data_b", 32'(rd_data_b), 32'h4100);
        step(2);
        check_eq("t1_w1_valid", 32'(rd_valid_a), 32'd1);
        check_eq("t1_w1_data",  32'(rd_data_a), 32'h00);
        step(2);
        check_eq("t1_w2_data",  32'(rd_data_a), 32'h42);
        step(1);
        check_eq("t1_done",     32'(rd_valid_a), 32'd0);

        // 4: stream again with a two-cycle stall on the second word
        set_mode(2'd3);
        mode = 2'd0;
        step(2);
        check_eq("t4_w0_data", 32'(rd_data_a), 32'h41);
        step(2);
        check_eq("t4_w1_data", 32'(rd_data_a), 32'h00);
        check_eq("t4_w1_valid", 32'(rd_valid_a), 32'd1);
        rd_ready = 1'b0;
        step(1);
        check_eq("t4_stall1_v", 32'(rd_valid_a), 32'd1);
        check_eq("t4_stall1_d", 32'(rd_data_a), 32'h00);
        step(1);
        check_eq("t4_stall2_v", 32'(rd_valid_a), 32'd1);
        rd_ready = 1'b1;
        step(1);
        check_eq("t4_gap", 32'(rd_valid_a), 32'd0);
        step(1);
        check_eq("t4_w2_data", 32'(rd_data_a), 32'h42);
        check_eq("t4_w2_valid", 32'(rd_valid_a), 32'd1);

        // 5: debug single-step with saturation at the last word
        set_mode(2'd2);
        check_eq("t5_valid", 32'(rd_valid_a), 32'd1);
        check_eq("t5_p0", 32'(rd_data_a), 32'h41);
        for (int i = 0; i < 5; i++) begin
            dbg_step = 1'b1;
            step(3);
            dbg_step = 1'b0;
            step(4);
            check_eq($sformatf("t5_p%0d", i + 1), 32'(rd_data_a), 32'(dbg_exp[i]));
        end

        // 5b: re-enter debug, single-cycle glitch advances exactly once
        set_mode(2'd3);
        set_mode(2'd2);
        check_eq("t5_reentry", 32'(rd_data_a), 32'h41);
        dbg_step = 1'b1;
        step(1);
        dbg_step = 1'b0;
        step(6);
        check_eq("t5_glitch", 32'(rd_data_a), 32'h00);

        // 6: back-to-back fetches, miss returns 0, reset mid-stream
        set_mode(2'd3);
        fetch_en = 1'b1;
        fetch_addr_a = 3'd0;
        step(1);
        check_eq("t6_f0_valid", 32'(fetch_valid_a), 32'd1);
        check_eq("t6_f0_data",  32'(fetch_data_a), 32'h41);
        fetch_addr_a = 3'd1;
        step(1);
        check_eq("t6_f1_valid", 32'(fetch_valid_a), 32'd1);
        check_eq("t6_f1_data",  32'(fetch_data_a), 32'h00);
        fetch_addr_a = 3'd7;
        step(1);
        check_eq("t6_f7_valid", 32'(fetch_valid_a), 32'd1);
        check_eq("t6_f7_data",  32'(fetch_data_a), 32'h00);
        fetch_en = 1'b0;
        rst = 1'b1;
        step(1);
        check_eq("t6_rst_fvalid", 32'(fetch_valid_a), 32'd0);
        check_eq("t6_rst_count",  32'(count_a), 32'd0);
        check_eq("t6_rst_rdv",    32'(rd_valid_a), 32'd0);
        check_eq("t6_rst_fdata",  32'(fetch_data_a), 32'd0);
        check_eq("t6_rst_cnt_b",  32'(count_b), 32'd0);
        rst = 1'b0;

        // 2: 16-bit assembly, second delimiter ignored
        set_mode(2'd1);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h24); send_byte(8'h24);
        check_eq("t2_count_b", 32'(count_b), 32'd1);
        set_mode(2'd3);
        fetch_en = 1'b1;
        fetch_addr_a = 3'd0;
        fetch_addr_b = 2'd0;
        step(1);
        fetch_en = 1'b0;
        check_eq("t2_word_b", 32'(fetch_data_b), 32'h1234);
        check_eq("t2_word_a", 32'(fetch_data_a), 32'h12);

        // Bytes outside LOAD are ignored
        send_byte(8'h55); send_byte(8'h24);
        check_eq("nolo_count_b", 32'(count_b), 32'd1);

        // 3: fill DEPTH=4, then one more commit overflows
        set_mode(2'd1);
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i));
            send_byte(8'h24);
            if (i == 4) begin
                check_eq("t3_full4",  32'(full_b), 32'd1);
                check_eq("t3_cnt4",   32'(count_b), 32'd4);
                check_eq("t3_ovf4",   32'(overflow_b), 32'd0);
            end
        end
        check_eq("t3_ovf5",   32'(overflow_b), 32'd1);
        check_eq("t3_cnt5",   32'(count_b), 32'd4);
        check_eq("t3_cnt5_a", 32'(count_a), 32'd5);
        check_eq("t3_full_a", 32'(full_a), 32'd0);
        set_mode(2'd3);
        set_mode(2'd1);
        check_eq("t3_clr_cnt",  32'(count_b), 32'd0);
        check_eq("t3_clr_ovf",  32'(overflow_b), 32'd0);
        check_eq("t3_clr_full", 32'(full_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
